// File: rtl/ahb_params_pkg.sv
// Shared AHB-Lite bus widths, transfer/response encodings and the memory-slave FSM state type.
package ahb_params_pkg;

    localparam int AHB_ADDR_WIDTH = 32;
    localparam int AHB_DATA_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        SLV_READY,
        SLV_WAIT,
        SLV_ERR1,
        SLV_ERR2
    } ahb_slv_state_e;

endpackage

// File: rtl/ahb_mem_bytelane_ram.sv
// Word-organised RAM with per-byte write enables, synchronous write and registered read.
// A read and a write to the same word on one edge return the old contents.
module ahb_mem_bytelane_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int NB        = DATA_WIDTH / 8,
    localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [NB-1:0]         wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory responder: byte/half/word access, two-cycle ERROR, write-to-read forwarding.
// Wait-state insertion (WAIT_CYCLES per OKAY transfer) is compiled in only with AHB_MEM_WAIT_EN.
module ahb_mem_slave
    import ahb_params_pkg::*;
#(
    parameter int ADDR_WIDTH  = AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = AHB_DATA_WIDTH,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    ahb_slv_state_e        state_reg;
    logic                  hreadyout_reg;
    logic [1:0]            hresp_reg;
    logic                  wr_pending_reg;
    logic                  rd_active_reg;
    logic [IDX_W-1:0]      dp_idx_reg;
    logic [OFF_W-1:0]      dp_off_reg;
    logic [2:0]            dp_size_reg;
    logic [DATA_WIDTH-1:0] fwd_mask_reg;
    logic [DATA_WIDTH-1:0] fwd_data_reg;
`ifdef AHB_MEM_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [CNT_W-1:0]      wait_cnt_reg;
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [OFF_W-1:0]      addr_off;
    logic [OFF_W-1:0]      align_mask;
    logic [IDX_W-1:0]      addr_idx;
    logic                  addr_err;
    logic                  take, take_wr, take_rd, commit, fwd_hit;
    logic [NB-1:0]         dp_strb;
    logic [NB-1:0]         ram_be;
    logic [DATA_WIDTH-1:0] commit_mask;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  unused_inputs;

    assign word_addr  = HADDR >> OFF_W;
    assign addr_off   = HADDR[OFF_W-1:0];
    assign addr_idx   = HADDR[OFF_W +: IDX_W];
    assign align_mask = ~({OFF_W{1'b1}} << HSIZE);
    assign addr_err   = (word_addr >= ADDR_WIDTH'(MEM_DEPTH)) || (HSIZE > 3'(OFF_W)) ||
                        ((addr_off & align_mask) != '0);

    // A new address phase is only accepted while our own previous data phase is completing.
    assign take    = HSEL & HREADY & HTRANS[1] & hreadyout_reg;
    assign take_wr = take & HWRITE & ~addr_err;
    assign take_rd = take & ~HWRITE & ~addr_err;
    assign commit  = wr_pending_reg & hreadyout_reg;
    assign fwd_hit = take_rd & commit & (addr_idx == dp_idx_reg);

    // Lane gi belongs to the transfer when it shares the size-aligned container with the offset.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign dp_strb[gi] = ((OFF_W'(gi) >> dp_size_reg) == (dp_off_reg >> dp_size_reg));
        assign commit_mask[gi*8 +: 8] = {8{dp_strb[gi]}};
    end
    assign ram_be = commit ? dp_strb : '0;

    ahb_mem_bytelane_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk     (HCLK),
        .wr_idx  (dp_idx_reg),
        .wr_be   (ram_be),
        .wr_data (HWDATA),
        .rd_en   (take_rd),
        .rd_idx  (addr_idx),
        .rd_data (ram_q)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg      <= SLV_READY;
            hreadyout_reg  <= 1'b1;
            hresp_reg      <= HRESP_OKAY;
            wr_pending_reg <= 1'b0;
            rd_active_reg  <= 1'b0;
            dp_idx_reg     <= '0;
            dp_off_reg     <= '0;
            dp_size_reg    <= '0;
            fwd_mask_reg   <= '0;
            fwd_data_reg   <= '0;
`ifdef AHB_MEM_WAIT_EN
            wait_cnt_reg   <= '0;
`endif
        end else begin
            if (hreadyout_reg) begin
                wr_pending_reg <= take_wr;
                rd_active_reg  <= take_rd;
                fwd_mask_reg   <= fwd_hit ? commit_mask : '0;
                if (fwd_hit) begin
                    fwd_data_reg <= HWDATA;
                end
                if (take) begin
                    dp_idx_reg  <= addr_idx;
                    dp_off_reg  <= addr_off;
                    dp_size_reg <= HSIZE;
                end
            end
            case (state_reg)
                SLV_READY, SLV_ERR2: begin
                    if (take && addr_err) begin
                        state_reg     <= SLV_ERR1;
                        hreadyout_reg <= 1'b0;
                        hresp_reg     <= HRESP_ERROR;
                    end
`ifdef AHB_MEM_WAIT_EN
                    else if (take && WAIT_CYCLES > 0) begin
                        state_reg     <= SLV_WAIT;
                        hreadyout_reg <= 1'b0;
                        hresp_reg     <= HRESP_OKAY;
                        wait_cnt_reg  <= CNT_W'(WAIT_CYCLES);
                    end
`endif
                    else begin
                        state_reg     <= SLV_READY;
                        hreadyout_reg <= 1'b1;
                        hresp_reg     <= HRESP_OKAY;
                    end
                end
`ifdef AHB_MEM_WAIT_EN
                SLV_WAIT: begin
                    if (wait_cnt_reg <= CNT_W'(1)) begin
                        state_reg     <= SLV_READY;
                        hreadyout_reg <= 1'b1;
                        wait_cnt_reg  <= '0;
                    end else begin
                        wait_cnt_reg  <= wait_cnt_reg - CNT_W'(1);
                    end
                end
`endif
                SLV_ERR1: begin
                    state_reg     <= SLV_ERR2;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= HRESP_ERROR;
                end
                default: begin
                    state_reg     <= SLV_READY;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_reg;
    assign HRESP     = hresp_reg;
    assign HRDATA    = rd_active_reg ? ((ram_q & ~fwd_mask_reg) | (fwd_data_reg & fwd_mask_reg)) : '0;

    assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed self-checking bench for ahb_mem_slave; single slave, so HREADY is looped back from HREADYOUT.
// Builds with or without AHB_MEM_WAIT_EN (WAIT_CYCLES = 2).
module tb_ahb_mem_slave;
    import ahb_params_pkg::*;

    localparam int MEM_DEPTH = 1024;
`ifdef AHB_MEM_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL    = 1'b0;
    logic [31:0] HADDR   = '0;
    logic [1:0]  HTRANS  = HTRANS_IDLE;
    logic        HWRITE  = 1'b0;
    logic [2:0]  HSIZE   = HSIZE_WORD;
    logic [2:0]  HBURST  = 3'b000;
    logic [3:0]  HPROT   = 4'b0011;
    logic [31:0] HWDATA  = '0;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    int checks = 0;
    int errors = 0;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_mem_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (MEM_DEPTH),
        .WAIT_CYCLES (2)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size);
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
    endtask

    task automatic idle_phase();
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (HREADYOUT !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (HREADYOUT !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: HREADYOUT=%b after %0d cycles, required 1", HREADYOUT, n);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, output int n);
        int pre;
        addr_phase(1'b1, addr, size);
        wait_ready(pre);
        step();
        HWDATA = data;
        idle_phase();
        wait_ready(n);
        step();
        $display("WR   addr=%08h size=%0d data=%08h waits=%0d", addr, size, data, n);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] size,
                           output logic [31:0] rdata, output logic [1:0] resp, output int n);
        addr_phase(1'b0, addr, size);
        step();
        idle_phase();
        wait_ready(n);
        rdata = HRDATA;
        resp  = HRESP;
        $display("RD   addr=%08h size=%0d data=%08h resp=%0d waits=%0d", addr, size, rdata, resp, n);
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== HRESP_OKAY || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: rdy=%b resp=%0d rdata=%08h, required 1/0/00000000", HREADYOUT, HRESP, HRDATA);
        end
        HRESETn = 1'b1;
        step();
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== HRESP_OKAY || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle: rdy=%b resp=%0d rdata=%08h, required 1/0/00000000", HREADYOUT, HRESP, HRDATA);
        end
        $display("RST  released");
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          n;
        do_write(32'h10, HSIZE_WORD, 32'hDEADBEEF, n);
        checks++;
        if (n !== EXP_WAITS) begin
            errors++;
            $display("FAIL wr_waits: got %0d, required %0d", n, EXP_WAITS);
        end
        do_read(32'h10, HSIZE_WORD, rd, rsp, n);
        checks++;
        if (rd !== 32'hDEADBEEF || rsp !== HRESP_OKAY || n !== EXP_WAITS) begin
            errors++;
            $display("FAIL wr_rd: data=%08h resp=%0d waits=%0d, required deadbeef/0/%0d", rd, rsp, n, EXP_WAITS);
        end
        step();
        checks++;
        if (HRDATA !== 32'h0 || HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL idle_dphase: rdata=%08h rdy=%b, required 00000000/1", HRDATA, HREADYOUT);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          n;
        do_write(32'h20, HSIZE_WORD, 32'h00000000, n);
        do_write(32'h21, HSIZE_BYTE, 32'h0000AA00, n);
        do_write(32'h22, HSIZE_HALF, 32'h55660000, n);
        do_read(32'h20, HSIZE_WORD, rd, rsp, n);
        checks++;
        if (rd !== 32'h5566AA00 || rsp !== HRESP_OKAY) begin
            errors++;
            $display("FAIL byte_lanes: data=%08h resp=%0d, required 5566aa00/0", rd, rsp);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          n;
        do_write(32'h30, HSIZE_WORD, 32'hA5A5A5A5, n);
        addr_phase(1'b1, 32'h30, HSIZE_WORD);
        wait_ready(n);
        step();
        HWDATA = 32'h12345678;
        addr_phase(1'b0, 32'h30, HSIZE_WORD);
        wait_ready(n);
        step();
        idle_phase();
        wait_ready(n);
        checks++;
        if (HRDATA !== 32'h12345678 || HRESP !== HRESP_OKAY || n !== EXP_WAITS) begin
            errors++;
            $display("FAIL fwd_word: data=%08h resp=%0d waits=%0d, required 12345678/0/%0d", HRDATA, HRESP, n, EXP_WAITS);
        end
        $display("FWD  word data=%08h", HRDATA);
        addr_phase(1'b1, 32'h33, HSIZE_BYTE);
        step();
        HWDATA = 32'h77000000;
        addr_phase(1'b0, 32'h30, HSIZE_WORD);
        wait_ready(n);
        step();
        idle_phase();
        wait_ready(n);
        checks++;
        if (HRDATA !== 32'h77345678) begin
            errors++;
            $display("FAIL fwd_byte: data=%08h, required 77345678", HRDATA);
        end
        $display("FWD  byte data=%08h", HRDATA);
        do_read(32'h30, HSIZE_WORD, rd, rsp, n);
        checks++;
        if (rd !== 32'h77345678) begin
            errors++;
            $display("FAIL fwd_commit: data=%08h, required 77345678", rd);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        addr_phase(1'b0, 32'h10, HSIZE_WORD);
        step();
        addr_phase(1'b0, 32'h20, HSIZE_WORD);
        wait_ready(n);
        checks++;
        if (HRDATA !== 32'hDEADBEEF || n !== EXP_WAITS) begin
            errors++;
            $display("FAIL b2b_first: data=%08h waits=%0d, required deadbeef/%0d", HRDATA, n, EXP_WAITS);
        end
        step();
        idle_phase();
        wait_ready(n);
        checks++;
        if (HRDATA !== 32'h5566AA00 || n !== EXP_WAITS) begin
            errors++;
            $display("FAIL b2b_second: data=%08h waits=%0d, required 5566aa00/%0d", HRDATA, n, EXP_WAITS);
        end
        $display("B2B  reads done");
        step();
    endtask

    task automatic test_error();
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          n;
        do_write(32'h00, HSIZE_WORD, 32'h0BADF00D, n);
        addr_phase(1'b0, MEM_DEPTH * 4, HSIZE_WORD);
        step();
        idle_phase();
        checks++;
        if (HREADYOUT !== 1'b0 || HRESP !== HRESP_ERROR || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL range_err1: rdy=%b resp=%0d rdata=%08h, required 0/1/00000000", HREADYOUT, HRESP, HRDATA);
        end
        step();
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== HRESP_ERROR || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL range_err2: rdy=%b resp=%0d rdata=%08h, required 1/1/00000000", HREADYOUT, HRESP, HRDATA);
        end
        $display("ERR  read addr=%08h", MEM_DEPTH * 4);
        addr_phase(1'b1, 32'h01, HSIZE_HALF);
        step();
        HWDATA = 32'hFFFFFFFF;
        idle_phase();
        checks++;
        if (HREADYOUT !== 1'b0 || HRESP !== HRESP_ERROR) begin
            errors++;
            $display("FAIL align_err1: rdy=%b resp=%0d, required 0/1", HREADYOUT, HRESP);
        end
        step();
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== HRESP_ERROR) begin
            errors++;
            $display("FAIL align_err2: rdy=%b resp=%0d, required 1/1", HREADYOUT, HRESP);
        end
        step();
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== HRESP_OKAY) begin
            errors++;
            $display("FAIL err_recover: rdy=%b resp=%0d, required 1/0", HREADYOUT, HRESP);
        end
        $display("ERR  write addr=00000001 size=1");
        addr_phase(1'b0, 32'h08, HSIZE_DWORD);
        step();
        idle_phase();
        checks++;
        if (HREADYOUT !== 1'b0 || HRESP !== HRESP_ERROR) begin
            errors++;
            $display("FAIL size_err: rdy=%b resp=%0d, required 0/1", HREADYOUT, HRESP);
        end
        $display("ERR  read addr=00000008 size=3");
        step();
        step();
        do_read(32'h00, HSIZE_WORD, rd, rsp, n);
        checks++;
        if (rd !== 32'h0BADF00D || rsp !== HRESP_OKAY) begin
            errors++;
            $display("FAIL err_nowrite: data=%08h resp=%0d, required 0badf00d/0", rd, rsp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          n;
        addr_phase(1'b0, MEM_DEPTH * 4, HSIZE_WORD);
        step();
        idle_phase();
        checks++;
        if (HREADYOUT !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_err: rdy=%b, required 0", HREADYOUT);
        end
        HRESETn = 1'b0;
        #1;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== HRESP_OKAY) begin
            errors++;
            $display("FAIL async_reset: rdy=%b resp=%0d, required 1/0", HREADYOUT, HRESP);
        end
        step();
        HRESETn = 1'b1;
        step();
        addr_phase(1'b1, 32'h10, HSIZE_WORD);
        step();
        HWDATA = 32'h11111111;
        idle_phase();
        HRESETn = 1'b0;
        #1;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== HRESP_OKAY || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b resp=%0d rdata=%08h, required 1/0/00000000", HREADYOUT, HRESP, HRDATA);
        end
        $display("RST  asserted during write addr=00000010");
        step();
        step();
        HRESETn = 1'b1;
        step();
        do_read(32'h10, HSIZE_WORD, rd, rsp, n);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_nocommit: data=%08h, required deadbeef", rd);
        end
    endtask

`ifdef AHB_MEM_WAIT_EN
    task automatic test_wait();
        addr_phase(1'b0, 32'h20, HSIZE_WORD);
        step();
        idle_phase();
        checks++;
        if (HREADYOUT !== 1'b0 || HRESP !== HRESP_OKAY) begin
            errors++;
            $display("FAIL wait_c1: rdy=%b resp=%0d, required 0/0", HREADYOUT, HRESP);
        end
        step();
        checks++;
        if (HREADYOUT !== 1'b0) begin
            errors++;
            $display("FAIL wait_c2: rdy=%b, required 0", HREADYOUT);
        end
        step();
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== HRESP_OKAY || HRDATA !== 32'h5566AA00) begin
            errors++;
            $display("FAIL wait_done: rdy=%b resp=%0d data=%08h, required 1/0/5566aa00", HREADYOUT, HRESP, HRDATA);
        end
        $display("WAIT read addr=00000020 data=%08h", HRDATA);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_forwarding();
        test_back_to_back();
        test_error();
        test_reset_mid();
`ifdef AHB_MEM_WAIT_EN
        test_wait();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
